param_updown_counter: RTL
=========================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, count width in bits (legal 2..32).
REQ-002 SHALL provide parameter MAX_VAL, default 2**WIDTH-1, terminal count (legal 1..2**WIDTH-1).
REQ-003 SHALL provide parameter SAT, default 0, limit mode (0 = wrap, 1 = saturate).
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous reset, active-low.
REQ-007 E  input  1  count enable.
REQ-008 D  input  1  direction (0 = up, 1 = down).
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  load value.
REQ-011 flag_clr  input  1  clears sticky flags.
REQ-012 count  output  WIDTH  registered count.
REQ-013 tc  output  1  registered limit-event pulse.
REQ-014 zero  output  1  combinational, count == 0.
REQ-015 at_max  output  1  combinational, count == MAX_VAL.
REQ-016 ovf_flag  output  1  sticky overflow flag.
REQ-017 unf_flag  output  1  sticky underflow flag.

Function
REQ-018 Per-edge priority SHALL be: load > (E=0 hold) > (E=1, D=0 up) > (E=1, D=1 down).
REQ-019 load SHALL set count to load_val when load_val <= MAX_VAL, otherwise to MAX_VAL (clamp); E and D are ignored that cycle.
REQ-020 Up with count < MAX_VAL SHALL give count+1; down with count > 0 SHALL give count-1.
REQ-021 Overflow event (ovf_evt) = E & !D & !load & count==MAX_VAL; underflow event (unf_evt) = E & D & !load & count==0.
REQ-022 SAT=0: ovf_evt SHALL load 0; unf_evt SHALL load MAX_VAL.
REQ-023 SAT=1: on either event count SHALL hold.
REQ-024 tc SHALL be 1 for exactly the cycle after each edge at which ovf_evt or unf_evt was true, else 0; consecutive events give consecutive tc cycles.
REQ-025 count SHALL never exceed MAX_VAL; arithmetic is WIDTH-bit, no carry out.
REQ-026 ovf_flag SHALL set on ovf_evt and unf_flag on unf_evt; both hold until flag_clr=1 at an edge.
REQ-027 Event and flag_clr at the same edge: set SHALL win.

Reset
REQ-028 rst=0 SHALL immediately force count=0, tc=0, ovf_flag=0, unf_flag=0, independent of clk.
REQ-029 Reset asserted mid-count SHALL discard any pending load or event; the first edge after deassertion operates on count=0.

Configuration
REQ-030 Macro UPDOWN_STICKY_FLAGS_EN defined: ovf_flag/unf_flag behave per REQ-026/027.
REQ-031 Macro undefined: ovf_flag and unf_flag SHALL be tied 0, flag_clr ignored, no flag registers; port list unchanged; all other behaviour identical.

Verification (WIDTH=4, MAX_VAL=9, macro defined unless stated)
REQ-032 SAT=0, reset, E=1 D=0 for 10 edges -> count 1..9 then 0; tc=1 only in the cycle count shows 0; ovf_flag=1.
REQ-033 SAT=0, count=0, E=1 D=1 one edge -> count=9, tc=1 one cycle, unf_flag=1, ovf_flag unchanged.
REQ-034 SAT=1, count=9, E=1 D=0 for 3 edges -> count stays 9, tc=1 for 3 cycles, at_max=1.
REQ-035 load=1 load_val=12 with E=1 D=0 -> count=9 (clamp), no tc; load_val=5 -> count=5.
REQ-036 ovf_evt with flag_clr=1 same edge -> ovf_flag=1; next edge flag_clr=1 alone -> ovf_flag=0; macro undefined -> flags always 0.
REQ-037 rst pulsed low between edges at count=7 -> count=0, tc=0, flags=0 before next clk edge; counting resumes 1, 2 after release.

Source files
------------

// File: rtl/param_updown_counter.sv
//==============================================================================
// Module   : param_updown_counter
// Purpose  : WIDTH-bit up/down counter with programmable terminal count
//            (MAX_VAL), wrap or saturate limit mode, clamped synchronous load,
//            registered limit-event pulse and optional sticky flags.
// Optional : define UPDOWN_STICKY_FLAGS_EN to build the sticky overflow /
//            underflow flag registers. When it is undefined the flags read 0
//            and flag_clr_i is ignored; the port list does not change.
// Ports    : clk_i        rising-edge clock
//            rst_ni       asynchronous reset, active-low
//            E_i          count enable
//            D_i          direction (0 = up, 1 = down)
//            load_i       synchronous load strobe (highest priority)
//            load_val_i   load value, clamped to MAX_VAL
//            flag_clr_i   clears sticky flags
//            count_o      registered count
//            tc_o         registered limit-event pulse
//            zero_o       count_o == 0 (combinational)
//            at_max_o     count_o == MAX_VAL (combinational)
//            ovf_flag_o   sticky overflow flag
//            unf_flag_o   sticky underflow flag
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module param_updown_counter #(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     MAX_VAL = {WIDTH{1'b1}},
  parameter bit                   SAT     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             E_i,
  input  logic             D_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             flag_clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             zero_o,
  output logic             at_max_o,
  output logic             ovf_flag_o,
  output logic             unf_flag_o
);

  localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  assign w_at_max  = (count_q == MAX_VAL);
  assign w_at_zero = (count_q == C_ZERO);

  // A limit event is a count attempt that would leave the 0..MAX_VAL range;
  // a load in the same cycle takes precedence and suppresses it.
  assign w_ovf_evt = E_i & ~D_i & ~load_i & w_at_max;
  assign w_unf_evt = E_i &  D_i & ~load_i & w_at_zero;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      // Out-of-range load values clamp so count never exceeds MAX_VAL.
      count_d = (load_val_i > MAX_VAL) ? MAX_VAL : load_val_i;
    end else if (E_i) begin
      if (!D_i) begin
        if (!w_at_max)
          count_d = count_q + C_ONE;
        else if (!SAT)
          count_d = C_ZERO;
      end else begin
        if (!w_at_zero)
          count_d = count_q - C_ONE;
        else if (!SAT)
          count_d = MAX_VAL;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= C_ZERO;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= w_ovf_evt | w_unf_evt;
    end
  end

`ifdef UPDOWN_STICKY_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // Setting has priority over clearing so an event coincident with
  // flag_clr_i is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (w_ovf_evt)
        ovf_q <= 1'b1;
      else if (flag_clr_i)
        ovf_q <= 1'b0;
      if (w_unf_evt)
        unf_q <= 1'b1;
      else if (flag_clr_i)
        unf_q <= 1'b0;
    end
  end

  assign ovf_flag_o = ovf_q;
  assign unf_flag_o = unf_q;
`else
  logic w_unused_flag_clr;
  assign w_unused_flag_clr = flag_clr_i;
  assign ovf_flag_o        = 1'b0;
  assign unf_flag_o        = 1'b0;
`endif

  assign count_o  = count_q;
  assign tc_o     = tc_q;
  assign zero_o   = w_at_zero;
  assign at_max_o = w_at_max;

endmodule

`default_nettype wire
